// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM req/ack/valid port between three ROM read ports and the IOCTL
// download writer; read returns are steered back through an in-order port-id FIFO.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    download_i,
  input  logic                    dl_req_i,
  input  logic [ADDR_WIDTH-1:0]   dl_addr_i,
  input  logic [DATA_WIDTH-1:0]   dl_data_i,
  output logic                    dl_ack_o,
  input  logic [2:0]              rd_req_i,
  input  logic [3*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [2:0]              rd_ack_o,
  output logic [2:0]              rd_valid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [ADDR_WIDTH-1:0]   sdram_addr_o,
  output logic [DATA_WIDTH-1:0]   sdram_data_o,
  output logic                    sdram_we_o,
  output logic                    sdram_req_o,
  input  logic                    sdram_ack_i,
  input  logic                    sdram_valid_i,
  input  logic [DATA_WIDTH-1:0]   sdram_q_i,
  output logic                    busy_o,
  output logic                    orphan_err_o
);
  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PENDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PENDING);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] sdram_addr_q;
  logic [DATA_WIDTH-1:0] sdram_data_q;
  logic                  we_q;
  logic                  sdram_req_q;
  logic [1:0]            port_q;
  logic [1:0]            rr_q;
  logic [2:0]            rd_ack_q;
  logic                  dl_ack_q;
  logic [2:0]            rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  orphan_q;
  logic [1:0]            fifo_mem_q [MAX_PENDING];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  logic [ADDR_WIDTH-1:0] rd_addr_arr [3];
  logic                  fifo_empty, fifo_full, push, pop;
  logic                  wr_grant, rd_grant, sel_found;
  logic [2:0]            rd_cand;
  logic [1:0]            sel_port, rr_next, idx_c;

  for (genvar gi = 0; gi < 3; gi++) begin : g_addr
    assign rd_addr_arr[gi] = rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop        = sdram_valid_i && !fifo_empty;
  assign push       = (state_q == ISSUE) && sdram_ack_i && !we_q;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  // The requester acked last cycle has not yet dropped its level request.
  assign rd_cand  = rd_req_i & ~rd_ack_q;
  assign wr_grant = download_i && dl_req_i && !dl_ack_q;
  assign rd_grant = !download_i && (!fifo_full || pop) && sel_found;

  always_comb begin
    sel_found = 1'b0;
    sel_port  = 2'd0;
    idx_c     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx_c = wrap3({1'b0, rr_q} + 3'(k));
      if (!sel_found && rd_cand[idx_c]) begin
        sel_found = 1'b1;
        sel_port  = idx_c;
      end
    end
  end

  assign rr_next = (sel_port == 2'd2) ? 2'd0 : sel_port + 2'd1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      sdram_addr_q <= '0;
      sdram_data_q <= '0;
      we_q         <= 1'b0;
      sdram_req_q  <= 1'b0;
      port_q       <= 2'd0;
      rr_q         <= 2'd0;
      rd_ack_q     <= 3'b000;
      dl_ack_q     <= 1'b0;
      rd_valid_q   <= 3'b000;
      rd_data_q    <= '0;
      orphan_q     <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rd_ack_q   <= 3'b000;
      dl_ack_q   <= 1'b0;
      rd_valid_q <= 3'b000;
      count_q    <= count_d;
      if (pop) begin
        rd_valid_q <= 3'b001 << fifo_mem_q[rd_ptr_q];
        rd_data_q  <= sdram_q_i;
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
      end
      if (sdram_valid_i && fifo_empty) orphan_q <= 1'b1;
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= port_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      case (state_q)
        IDLE: begin
          if (wr_grant) begin
            state_q      <= ISSUE;
            sdram_req_q  <= 1'b1;
            we_q         <= 1'b1;
            sdram_addr_q <= dl_addr_i;
            sdram_data_q <= dl_data_i;
          end else if (rd_grant) begin
            state_q      <= ISSUE;
            sdram_req_q  <= 1'b1;
            we_q         <= 1'b0;
            sdram_addr_q <= rd_addr_arr[sel_port];
            port_q       <= sel_port;
            rr_q         <= rr_next;
          end
        end
        ISSUE: begin
          if (sdram_ack_i) begin
            state_q     <= IDLE;
            sdram_req_q <= 1'b0;
            we_q        <= 1'b0;
            if (we_q) dl_ack_q <= 1'b1;
            else      rd_ack_q <= 3'b001 << port_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dl_ack_o     = dl_ack_q;
  assign rd_ack_o     = rd_ack_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign sdram_addr_o = sdram_addr_q;
  assign sdram_data_o = sdram_data_q;
  assign sdram_we_o   = we_q;
  assign sdram_req_o  = sdram_req_q;
  assign busy_o       = (state_q != IDLE) || !fifo_empty;
  assign orphan_err_o = orphan_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a cycle table, directed corner sequences, and a
// randomized run against a queue-based SDRAM/requester model.
module tb_sdram_port_arbiter;
  localparam int AW   = 23;
  localparam int DW   = 32;
  localparam int MAXP = 2;
  localparam int NRAND = 3000;
  localparam int NDRAIN = 400;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          download = 1'b0;
  logic          dl_req = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic          dl_ack;
  logic [2:0]    rd_req = 3'b000;
  logic [3*AW-1:0] rd_addr = '0;
  logic [2:0]    rd_ack, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_data;
  logic          sdram_we, sdram_req;
  logic          sdram_ack = 1'b0;
  logic          sdram_valid = 1'b0;
  logic [DW-1:0] sdram_q = '0;
  logic          busy, orphan_err;

  int tests = 0;
  int fails = 0;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MAXP)) dut (
    .clk_i(clk), .reset_i(reset), .download_i(download),
    .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_ack_o(dl_ack),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .sdram_addr_o(sdram_addr), .sdram_data_o(sdram_data), .sdram_we_o(sdram_we),
    .sdram_req_o(sdram_req), .sdram_ack_i(sdram_ack), .sdram_valid_i(sdram_valid),
    .sdram_q_i(sdram_q), .busy_o(busy), .orphan_err_o(orphan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (tests %0d)", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; download = 1'b0; dl_req = 1'b0; rd_req = 3'b000;
    sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] hash(input logic [AW-1:0] a);
    return {a[7:0], 1'b1, a} ^ 32'h5a3c_96e1;
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic        ack;
    logic        vld;
    logic [31:0] q;
    logic        e_req;
    logic [AW-1:0] e_addr;
    logic [2:0]  e_ack;
    logic [2:0]  e_vld;
    logic [31:0] e_data;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            port;
  } ent_t;

  vec_t vecs [13];
  ent_t sq [$];

  initial begin
    logic [2:0]    rq;
    logic [AW-1:0] ra [3];
    int            waitc [3];
    logic          ack_prev_rd, vld_prev, req_hold;
    logic [AW-1:0] addr_prev;
    ent_t          ret_e;
    int            p;

    // Three fixed-address readers; FIFO depth 2 stalls the third grant until a return.
    vecs[0]  = '{3'b111, 1'b0, 1'b0, 32'h0,        1'b1, 23'h100, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[1]  = '{3'b111, 1'b0, 1'b0, 32'h0,        1'b1, 23'h100, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[2]  = '{3'b111, 1'b1, 1'b0, 32'h0,        1'b0, 23'h100, 3'b001, 3'b000, 32'h0,        1'b1};
    vecs[3]  = '{3'b110, 1'b0, 1'b0, 32'h0,        1'b1, 23'h200, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[4]  = '{3'b110, 1'b1, 1'b0, 32'h0,        1'b0, 23'h200, 3'b010, 3'b000, 32'h0,        1'b1};
    vecs[5]  = '{3'b100, 1'b0, 1'b0, 32'h0,        1'b0, 23'h200, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[6]  = '{3'b100, 1'b0, 1'b0, 32'h0,        1'b0, 23'h200, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[7]  = '{3'b100, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 23'h300, 3'b000, 3'b001, 32'hA5A5A5A5, 1'b1};
    vecs[8]  = '{3'b100, 1'b1, 1'b1, 32'h12345678, 1'b0, 23'h300, 3'b100, 3'b010, 32'h12345678, 1'b1};
    vecs[9]  = '{3'b001, 1'b0, 1'b0, 32'h0,        1'b1, 23'h100, 3'b000, 3'b000, 32'h0,        1'b1};
    vecs[10] = '{3'b001, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 23'h100, 3'b001, 3'b100, 32'hCAFEF00D, 1'b1};
    vecs[11] = '{3'b000, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 23'h100, 3'b000, 3'b001, 32'h0BADF00D, 1'b0};
    vecs[12] = '{3'b000, 1'b0, 1'b0, 32'h0,        1'b0, 23'h100, 3'b000, 3'b000, 32'h0,        1'b0};

    tick();
    do_reset();
    check("reset_outputs", {sdram_req, sdram_we, busy, orphan_err, dl_ack, rd_ack, rd_valid}, '0);
    check("reset_addr", sdram_addr, '0);

    rd_addr = {23'h300, 23'h200, 23'h100};
    for (int i = 0; i < 13; i++) begin
      rd_req = vecs[i].req; sdram_ack = vecs[i].ack;
      sdram_valid = vecs[i].vld; sdram_q = vecs[i].q;
      tick();
      $display("[TB] vec %0d req=%b ack=%b vld=%b -> sreq=%b addr=%0h rd_ack=%b rd_valid=%b",
               i, vecs[i].req, vecs[i].ack, vecs[i].vld, sdram_req, sdram_addr, rd_ack, rd_valid);
      check($sformatf("vec%0d_sdram_req", i), sdram_req, vecs[i].e_req);
      check($sformatf("vec%0d_sdram_addr", i), sdram_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_rd_ack", i), rd_ack, vecs[i].e_ack);
      check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_vld);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_vld != 3'b000) check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
    end
    sdram_ack = 1'b0; sdram_valid = 1'b0; rd_req = 3'b000;

    // Download has priority and blocks reads; falling download with dl_req high grants no write.
    do_reset();
    rd_addr = {23'h0, 23'h0, 23'h000040};
    download = 1'b1; dl_req = 1'b1; dl_addr = 23'h000100; dl_data = 32'hDEADBEEF; rd_req = 3'b001;
    tick();
    $display("[TB] download write grant: req=%b we=%b addr=%0h data=%0h", sdram_req, sdram_we, sdram_addr, sdram_data);
    check("dl_write_req", {sdram_req, sdram_we}, 2'b11);
    check("dl_write_addr", sdram_addr, 23'h000100);
    check("dl_write_data", sdram_data, 32'hDEADBEEF);
    sdram_ack = 1'b1;
    tick();
    check("dl_ack_pulse", {dl_ack, rd_ack, sdram_req, sdram_we}, {1'b1, 3'b000, 1'b0, 1'b0});
    sdram_ack = 1'b0; dl_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dl_read_blocked", sdram_req, 1'b0);
    end
    download = 1'b0; dl_req = 1'b1;
    tick();
    check("dl_fall_read_grant", {sdram_req, sdram_we}, 2'b10);
    check("dl_fall_read_addr", sdram_addr, 23'h000040);
    sdram_ack = 1'b1;
    tick();
    check("dl_fall_read_ack", {rd_ack, dl_ack}, {3'b001, 1'b0});
    sdram_ack = 1'b0; rd_req = 3'b000; dl_req = 1'b0; sdram_valid = 1'b1; sdram_q = 32'h0F0F1234;
    tick();
    check("dl_fall_return", {rd_valid, rd_data}, {3'b001, 32'h0F0F1234});
    sdram_valid = 1'b0;

    // Orphan return with an empty FIFO is sticky until reset.
    do_reset();
    sdram_valid = 1'b1; sdram_q = 32'h11112222;
    tick();
    $display("[TB] orphan valid: orphan_err=%b rd_valid=%b", orphan_err, rd_valid);
    check("orphan_set", {orphan_err, rd_valid}, {1'b1, 3'b000});
    sdram_valid = 1'b0;
    tick(); tick();
    check("orphan_sticky", orphan_err, 1'b1);
    do_reset();
    check("orphan_cleared", orphan_err, 1'b0);

    // Reset during ISSUE with one read pending drops everything.
    rd_addr = {23'h3, 23'h2, 23'h1};
    rd_req = 3'b001;
    tick();
    sdram_ack = 1'b1;
    tick();
    check("rst_seq_ack0", rd_ack, 3'b001);
    sdram_ack = 1'b0; rd_req = 3'b010;
    tick();
    check("rst_seq_issue", {sdram_req, sdram_addr}, {1'b1, 23'h2});
    reset = 1'b1;
    tick();
    $display("[TB] reset in ISSUE: req=%b busy=%b", sdram_req, busy);
    check("rst_seq_cleared", {sdram_req, busy, rd_ack}, {1'b0, 1'b0, 3'b000});
    reset = 1'b0; rd_req = 3'b000;
    tick();
    sdram_valid = 1'b1;
    tick();
    check("rst_seq_orphan", {orphan_err, rd_valid}, {1'b1, 3'b000});
    sdram_valid = 1'b0;

    // Randomized reads against the SDRAM/requester model.
    do_reset();
    rq = 3'b000; ack_prev_rd = 1'b0; vld_prev = 1'b0; req_hold = 1'b0; addr_prev = '0;
    ret_e = '{'0, -1};
    for (int i = 0; i < 3; i++) begin ra[i] = '0; waitc[i] = 0; end
    for (int cyc = 0; cyc < NRAND + NDRAIN; cyc++) begin
      tick();
      p = -1;
      if (ack_prev_rd) begin
        for (int i = 0; i < 3; i++) if (rd_ack[i]) p = i;
        check("rnd_ack_onehot", 32'($countones(rd_ack)), 1);
        if (p >= 0) begin
          check("rnd_ack_req", rq[p], 1'b1);
          check("rnd_ack_addr", sq[sq.size()-1].addr, ra[p]);
          sq[sq.size()-1].port = p;
          rq[p] = 1'b0;
          waitc[p] = 0;
        end
      end else begin
        check("rnd_no_ack", rd_ack, 3'b000);
      end
      if (vld_prev) begin
        check("rnd_valid_port", rd_valid, (ret_e.port < 0) ? 3'b000 : (3'b001 << ret_e.port));
        check("rnd_valid_data", rd_data, hash(ret_e.addr));
      end else begin
        check("rnd_no_valid", rd_valid, 3'b000);
      end
      if (req_hold) begin
        check("rnd_req_held", sdram_req, 1'b1);
        check("rnd_addr_held", sdram_addr, addr_prev);
      end
      if (sdram_req) check("rnd_no_write", sdram_we, 1'b0);
      for (int i = 0; i < 3; i++) begin
        if (rq[i]) begin
          waitc[i]++;
          if (waitc[i] == 300) check("rnd_starve", rq[i], 1'b0);
        end else if (cyc < NRAND && i != p && $urandom_range(3) == 0) begin
          rq[i] = 1'b1;
          ra[i] = AW'($urandom);
        end
      end
      rd_req = rq;
      rd_addr = {ra[2], ra[1], ra[0]};
      vld_prev = 1'b0;
      sdram_valid = 1'b0;
      sdram_q = $urandom;
      if (sq.size() > 0 && (cyc >= NRAND + NDRAIN - 30 || $urandom_range(9) < 4)) begin
        ret_e = sq.pop_front();
        vld_prev = 1'b1;
        sdram_valid = 1'b1;
        sdram_q = hash(ret_e.addr);
      end
      if (sdram_req && cyc < NRAND + NDRAIN - 30 && $urandom_range(1) == 1) begin
        sdram_ack = 1'b1;
        ack_prev_rd = !sdram_we;
        req_hold = 1'b0;
        if (!sdram_we) begin
          sq.push_back('{sdram_addr, -1});
          check("rnd_pending_bound", sq.size() <= MAXP, 1'b1);
        end
      end else begin
        sdram_ack = 1'b0;
        ack_prev_rd = 1'b0;
        req_hold = sdram_req;
        addr_prev = sdram_addr;
      end
    end
    sdram_ack = 1'b0; sdram_valid = 1'b0;
    tick(); tick();
    $display("[TB] random phase done: outstanding=%0d pending_req=%b busy=%b", sq.size(), rq, busy);
    check("rnd_drained", 32'(sq.size()), 0);
    check("rnd_all_served", rq, 3'b000);
    check("rnd_idle", {busy, sdram_req, orphan_err}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
